// File: rtl/bus_sync_src_drv.sv
// bus_sync_src_drv: source-domain transmitter feeding bus_sync.
// Buffers producer words in a small FIFO. Hands each word to bus_sync as a
// single-cycle valid pulse, and only when bus_sync reports ready. It then
// waits for ready to drop (acknowledge) and recover before the next word.
//
// Ports:
//   i_clk, rst_n       clock (rising edge), synchronous active-low reset
//   i_data, i_valid    producer push; accepted when o_ready is high
//   o_ready            FIFO not full (level < DEPTH)
//   o_src_data/valid   word + one-cycle strobe to bus_sync
//   i_sync_ready       bus_sync ready, already in this clock domain
//   o_level            FIFO occupancy
//   o_xact_cnt         words handed to bus_sync (wraps)
//   o_tmo_err          sticky: ready failed to drop within ACK_TMO cycles
module bus_sync_src_drv #(
  parameter int DWIDTH  = 4,
  parameter int DEPTH   = 4,
  parameter int ACK_TMO = 16
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DWIDTH-1:0]        o_src_data,
  output logic                     o_src_valid,
  input  logic                     i_sync_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_xact_cnt,
  output logic                     o_tmo_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(ACK_TMO);  // holds ACK_TMO-1, the terminal count

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_RDY} st_t;

  st_t               st, st_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [TW-1:0]     tmo_cnt;
  logic              push, pop, tmo_hit;

  // Ready depends on the registered level only, so a same-edge pop never
  // opens a slot for a push.
  assign o_ready = (level < LW'(DEPTH));
  assign o_level = level;
  assign push    = i_valid && o_ready;

  always_comb begin
    st_nxt  = st;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (st)
      IDLE:     if (level != '0 && i_sync_ready) begin
                  pop    = 1'b1;
                  st_nxt = SEND;
                end
      SEND:     st_nxt = WAIT_ACK;
      WAIT_ACK: if (!i_sync_ready) st_nxt = WAIT_RDY;
                else if (tmo_cnt == TW'(ACK_TMO - 1)) begin
                  // Ready never dropped: flag it and treat the word as sent.
                  tmo_hit = 1'b1;
                  st_nxt  = WAIT_RDY;
                end
      WAIT_RDY: if (i_sync_ready) st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  // Storage has no reset; contents are meaningless while level is 0.
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_data;

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      tmo_cnt     <= '0;
      o_src_valid <= 1'b0;
      o_src_data  <= '0;
      o_xact_cnt  <= '0;
      o_tmo_err   <= 1'b0;
    end else begin
      st <= st_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      // Valid is high exactly for the SEND cycle; data holds until next pop.
      o_src_valid <= pop;
      if (pop) o_src_data <= mem[rd_ptr];
      if (st == SEND) begin
        o_xact_cnt <= o_xact_cnt + 1'b1;
        tmo_cnt    <= '0;
      end else if (st == WAIT_ACK && i_sync_ready && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) o_tmo_err <= 1'b1;
    end
  end
endmodule
